data_memory: RTL and testbench

Doubleword-wide data memory for the single-cycle ARM (LEGv8-style) datapath. It sits after the ALU in the MEM stage: the ALU result is the byte address, register-file read data 2 is the store data, and `readData` feeds the write-back mux. Writes happen on the clock edge. Reads are combinational, so a load completes within the same cycle.

---
 rtl/data_memory.sv | 63 ++++++
 tb/tb_data_memory.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Doubleword data memory for the single-cycle datapath: edge-written, combinationally read.
// Optional macro DATA_MEMORY_PRELOAD_EN makes entry i reset to the value i instead of 0.
module data_memory #(
  parameter int BITSIZE = 64,
  parameter int DEPTH   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BITSIZE-1:0] address,
  input  logic [BITSIZE-1:0] writeData,
  input  logic               memWrite,
  input  logic               memRead,
  output logic [BITSIZE-1:0] readData
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]      index;
  logic [BITSIZE-1:0] mem_q [DEPTH];
  logic [BITSIZE-1:0] read_data_d;

  function automatic logic [BITSIZE-1:0] reset_value(input int entry);
`ifdef DATA_MEMORY_PRELOAD_EN
    return BITSIZE'(entry);
`else
    return (entry < 0) ? '1 : '0;
`endif
  endfunction

  // Byte offset and bits above the index field take no part in addressing.
  assign index = address[3 +: AW];

  generate
    if (BITSIZE > 3 + AW) begin : g_hi_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^{address[2:0], address[BITSIZE-1:3+AW]};
    end else begin : g_lo_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^address[2:0];
    end
  endgenerate

  // Reset has priority, so a write on an edge coinciding with reset is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= reset_value(i);
      end
    end else if (memWrite) begin
      mem_q[index] <= writeData;
    end
  end

  always_comb begin
    read_data_d = '0;
    if (memRead) begin
      read_data_d = mem_q[index];
    end
  end

  assign readData = read_data_d;

endmodule

// File: tb/tb_data_memory.sv
// Randomized self-checking bench for data_memory against an array-based reference model.
module tb_data_memory;
  localparam int BITSIZE = 64;
  localparam int DEPTH   = 32;

  logic               clk;
  logic               rst;
  logic [BITSIZE-1:0] address;
  logic [BITSIZE-1:0] writeData;
  logic               memWrite;
  logic               memRead;
  logic [BITSIZE-1:0] readData;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] model_mem [DEPTH];

  data_memory #(.BITSIZE(BITSIZE), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .writeData (writeData),
    .memWrite  (memWrite),
    .memRead   (memRead),
    .readData  (readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model_reset_value(input int entry);
`ifdef DATA_MEMORY_PRELOAD_EN
    return 64'(entry);
`else
    return (entry < 0) ? 64'd1 : 64'd0;
`endif
  endfunction

  function automatic int model_index(input logic [63:0] addr);
    return int'((addr / 64'd8) % 64'(DEPTH));
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] addr, input logic re);
    return re ? model_mem[model_index(addr)] : 64'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = model_reset_value(i);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: readData=%h expected=%h", tag, got, exp);
    end
  endtask

  // One transaction: drive after the falling edge, check before and after the rising edge.
  task automatic apply(input string tag, input logic [63:0] addr, input logic [63:0] wd,
                       input logic we, input logic re);
    address   = addr;
    writeData = wd;
    memWrite  = we;
    memRead   = re;
    #1;
    check({tag, "_pre"}, readData, model_read(addr, re));
    @(posedge clk);
    if (rst && we) model_mem[model_index(addr)] = wd;
    #1;
    check({tag, "_post"}, readData, model_read(addr, re));
    $display("[TB] %s addr=%h wd=%h we=%0b re=%0b rst=%0b rd=%h", tag, addr, wd, we, re, rst, readData);
    @(negedge clk);
  endtask

  task automatic async_reset_pulse(input logic [63:0] addr);
    address = addr;
    memRead = 1'b1;
    memWrite = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_rst", readData, model_reset_value(model_index(addr)));
    $display("[TB] async reset addr=%h rd=%h", addr, readData);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rw;
    rst = 1'b0;
    address = '0;
    writeData = '0;
    memWrite = 1'b0;
    memRead = 1'b0;
    model_reset();
    @(negedge clk);

    // Writes are ignored while reset is held.
    for (int i = 0; i < 10; i++) apply("rst_write", 64'd1, 64'd3, 1'b1, 1'b0);
    apply("rst_read", 64'd1, 64'd0, 1'b0, 1'b1);
    check("rst_read_val", readData, 64'd0);

    rst = 1'b1;
    apply("store", 64'd1, 64'd3, 1'b1, 1'b1);
    check("store_val", readData, 64'd3);
    for (int a = 0; a < 8; a++) apply("load_off", 64'(a), 64'd0, 1'b0, 1'b1);

    apply("gate_off", 64'd0, 64'd0, 1'b0, 1'b0);
    check("gate_off_val", readData, 64'd0);
    memRead = 1'b1;
    #1;
    check("gate_on_comb", readData, 64'd3);
    @(negedge clk);

    apply("wr_aa", 64'd8, 64'hAA, 1'b1, 1'b0);
    apply("wr_55", 64'(DEPTH * 8 + 16), 64'h55, 1'b1, 1'b0);
    apply("rd_8", 64'd8, 64'd0, 1'b0, 1'b1);
    check("rd_8_val", readData, 64'hAA);
    apply("rd_16", 64'd16, 64'd0, 1'b0, 1'b1);
    check("rd_16_val", readData, 64'h55);
    apply("rd_24", 64'd24, 64'd0, 1'b0, 1'b1);
    check("rd_24_val", readData, model_reset_value(3));

    apply("rw_same", 64'd8, 64'h77, 1'b1, 1'b1);
    check("rw_same_val", readData, 64'h77);

    async_reset_pulse(64'd8);
    apply("after_rst", 64'd16, 64'd0, 1'b0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      if ((n % 50) == 49) begin
        async_reset_pulse({$urandom, $urandom});
      end else begin
        ra = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 511));
        rw = {$urandom, $urandom};
        apply("rand", ra, rw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end
    end

    // Full sweep of the model against the array.
    for (int i = 0; i < DEPTH; i++) apply("sweep", 64'(i * 8), 64'd0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
